// File: rtl/adc128s022_responder.sv
// Purpose: converter-side model of the ADC128S022 serial link (dout answers adc_sck/adc_cs_n/din).
// Latency: dout follows a pin edge within SYNC_STAGES+2 clk_50 cycles; the address lags one frame.
// Backpressure: none; the initiator owns the link timing and every detected edge is acted on.
// Ports: clk_50/rst_n (sync, active-low); adc_sck, adc_cs_n, din, dout form the serial link;
//        ch_data carries channel k at [12k+11:12k]; cur_addr, last_sample, frame_done and
//        frame_error report the frame status.
module adc128s022_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] INIT_ADDR   = 3'd0
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        adc_sck,
    input  logic        adc_cs_n,
    input  logic        din,
    output logic        dout,
    input  logic [95:0] ch_data,
    output logic [2:0]  cur_addr,
    output logic [11:0] last_sample,
    output logic        frame_done,
    output logic        frame_error
);

    typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE, DONE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, din_sync;
    logic sck_s, cs_s, din_s;
    logic sck_d, cs_d;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    state_t      state, state_nxt;
    logic [4:0]  rise_cnt, rise_cnt_nxt, fall_cnt, fall_cnt_nxt;
    logic [4:0]  rise_inc, fall_inc;
    logic [2:0]  next_addr, next_addr_nxt, cur_addr_nxt;
    logic [11:0] sample, sample_nxt, last_sample_nxt, ch_sel;
    logic [6:0]  sel_base;
    logic [3:0]  bit_idx;
    logic        dout_nxt, frame_done_nxt, frame_error_nxt;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign sel_base = {4'd0, cur_addr} * 7'd12;
    assign ch_sel   = ch_data[sel_base +: 12];
    assign rise_inc = rise_cnt + 5'd1;
    assign fall_inc = fall_cnt + 5'd1;
    // Fall 5..15 shifts sample[10..0]; only meaningful in that range.
    assign bit_idx  = 4'd15 - fall_inc[3:0];

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            // cs_n synchronizer resets to "asserted" so WAIT_CS_HIGH only leaves on a
            // genuinely high pin, never on stale reset values.
            sck_sync    <= '0;
            cs_sync     <= '0;
            din_sync    <= '0;
            sck_d       <= 1'b0;
            cs_d        <= 1'b0;
            state       <= WAIT_CS_HIGH;
            rise_cnt    <= '0;
            fall_cnt    <= '0;
            next_addr   <= '0;
            sample      <= '0;
            dout        <= 1'b0;
            cur_addr    <= INIT_ADDR;
            last_sample <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            din_sync    <= {din_sync[SYNC_STAGES-2:0], din};
            sck_d       <= sck_s;
            cs_d        <= cs_s;
            state       <= state_nxt;
            rise_cnt    <= rise_cnt_nxt;
            fall_cnt    <= fall_cnt_nxt;
            next_addr   <= next_addr_nxt;
            sample      <= sample_nxt;
            dout        <= dout_nxt;
            cur_addr    <= cur_addr_nxt;
            last_sample <= last_sample_nxt;
            frame_done  <= frame_done_nxt;
            frame_error <= frame_error_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        rise_cnt_nxt    = rise_cnt;
        fall_cnt_nxt    = fall_cnt;
        next_addr_nxt   = next_addr;
        sample_nxt      = sample;
        dout_nxt        = dout;
        cur_addr_nxt    = cur_addr;
        last_sample_nxt = last_sample;
        frame_done_nxt  = 1'b0;
        frame_error_nxt = 1'b0;

        case (state)
            WAIT_CS_HIGH: begin
                dout_nxt = 1'b0;
                if (cs_s) state_nxt = IDLE;
            end
            IDLE: begin
                dout_nxt = 1'b0;
                if (cs_fall) begin
                    state_nxt    = ACTIVE;
                    rise_cnt_nxt = '0;
                    fall_cnt_nxt = '0;
                end
            end
            ACTIVE: begin
                // A chip-select edge wins over any SCK edge seen in the same cycle.
                if (cs_rise) begin
                    state_nxt       = IDLE;
                    dout_nxt        = 1'b0;
                    frame_error_nxt = 1'b1;
                end else if (sck_rise) begin
                    rise_cnt_nxt = rise_inc;
                    case (rise_inc)
                        5'd3:    next_addr_nxt[2] = din_s;
                        5'd4:    next_addr_nxt[1] = din_s;
                        5'd5:    next_addr_nxt[0] = din_s;
                        default: ;
                    endcase
                    if (rise_inc == 5'd16) begin
                        state_nxt       = DONE;
                        dout_nxt        = 1'b0;
                        cur_addr_nxt    = next_addr;
                        last_sample_nxt = sample;
                        frame_done_nxt  = 1'b1;
                    end
                end else if (sck_fall) begin
                    fall_cnt_nxt = fall_inc;
                    if (fall_inc == 5'd4) begin
                        // Conversion point: later ch_data changes cannot reach this frame.
                        sample_nxt = ch_sel;
                        dout_nxt   = ch_sel[11];
                    end else if (fall_inc >= 5'd5 && fall_inc <= 5'd15) begin
                        dout_nxt = sample[bit_idx];
                    end else begin
                        dout_nxt = 1'b0;
                    end
                end
            end
            DONE: begin
                dout_nxt = 1'b0;
                if (cs_rise) state_nxt = IDLE;
            end
            default: begin
                state_nxt = WAIT_CS_HIGH;
                dout_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Purpose: directed bench for adc128s022_responder acting as the serial initiator.
// Latency: SCK half period is 10 clk_50 cycles, dout sampled just before each SCK rise.
// Backpressure: not applicable; the bench drives the link freely.
module tb_adc128s022_responder;

    localparam int SYNC = 2;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        adc_sck;
    logic        adc_cs_n;
    logic        din;
    logic        dout;
    logic [95:0] ch_data;
    logic [2:0]  cur_addr;
    logic [11:0] last_sample;
    logic        frame_done;
    logic        frame_error;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    adc128s022_responder #(.SYNC_STAGES(SYNC), .INIT_ADDR(3'd0)) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .adc_sck     (adc_sck),
        .adc_cs_n    (adc_cs_n),
        .din         (din),
        .dout        (dout),
        .ch_data     (ch_data),
        .cur_addr    (cur_addr),
        .last_sample (last_sample),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #10 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    // One full 16-clock frame, SCK idling low. Optional ch_data change after a given
    // fall and optional reset pulse just before a given rise (0 disables either).
    task automatic run_frame(input logic [2:0] addr, input int chg_fall,
                             input logic [95:0] chg_val, input int rst_rise,
                             output logic [15:0] rx);
        rx = '0;
        adc_cs_n = 1'b0;
        wait_clks(10);
        for (int i = 1; i <= 16; i++) begin
            din = (i >= 3 && i <= 5) ? addr[5-i] : 1'b0;
            if (i == rst_rise) begin
                rst_n = 1'b0;
                wait_clks(2);
                rst_n = 1'b1;
            end
            wait_clks(10);
            rx = {rx[14:0], dout};
            adc_sck = 1'b1;
            wait_clks(10);
            adc_sck = 1'b0;
            if (i == chg_fall) ch_data = chg_val;
        end
        wait_clks(10);
        adc_cs_n = 1'b1;
        wait_clks(12);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; adc_cs_n = 1'b1; adc_sck = 1'b0; din = 1'b0;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(1);
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout got %b want 0", dout); end
        vectors++; if (cur_addr !== 3'd0) begin miscompares++; $display("FAIL reset_cur_addr got %0d want 0", cur_addr); end
        vectors++; if (last_sample !== 12'h000) begin miscompares++; $display("FAIL reset_last_sample got %h want 000", last_sample); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
        wait_clks(10);
    endtask

    task automatic test_basic;
        logic [15:0] rx;
        int d0;
        d0 = done_cnt;
        run_frame(3'd0, 0, ch_data, 0, rx);
        vectors++; if (rx !== 16'h0123) begin miscompares++; $display("FAIL basic_data got %h want 0123", rx); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
        vectors++; if (cur_addr !== 3'd0) begin miscompares++; $display("FAIL basic_cur_addr got %0d want 0", cur_addr); end
        vectors++; if (last_sample !== 12'h123) begin miscompares++; $display("FAIL basic_last_sample got %h want 123", last_sample); end
    endtask

    // Addresses 5,6,7,5: data lags the written address by one frame.
    task automatic test_back_to_back;
        logic [2:0]  addrs [4] = '{3'd5, 3'd6, 3'd7, 3'd5};
        logic [15:0] exp_rx [4] = '{16'h0123, 16'h0ABC, 16'h07FF, 16'h0001};
        logic [15:0] rx;
        int d0;
        for (int f = 0; f < 4; f++) begin
            d0 = done_cnt;
            run_frame(addrs[f], 0, ch_data, 0, rx);
            vectors++; if (rx !== exp_rx[f]) begin miscompares++; $display("FAIL b2b_data[%0d] got %h want %h", f, rx, exp_rx[f]); end
            vectors++; if (cur_addr !== addrs[f]) begin miscompares++; $display("FAIL b2b_cur_addr[%0d] got %0d want %0d", f, cur_addr, addrs[f]); end
            vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL b2b_done[%0d] got %0d want 1", f, done_cnt - d0); end
        end
        vectors++; if (last_sample !== 12'h001) begin miscompares++; $display("FAIL b2b_last_sample got %h want 001", last_sample); end
    endtask

    // cs_n raised while SCK is high after rise 9; dout was carrying ch5 bit 7.
    task automatic test_abort;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        adc_cs_n = 1'b0;
        wait_clks(10);
        for (int i = 1; i <= 9; i++) begin
            din = 1'b0;
            wait_clks(10);
            adc_sck = 1'b1;
            wait_clks(10);
            if (i < 9) adc_sck = 1'b0;
        end
        vectors++; if (dout !== 1'b1) begin miscompares++; $display("FAIL abort_mid_bit got %b want 1", dout); end
        adc_cs_n = 1'b1;
        wait_clks(SYNC + 2);
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL abort_dout got %b want 0", dout); end
        adc_sck = 1'b0;
        wait_clks(10);
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL abort_error got %0d want 1", err_cnt - e0); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
        vectors++; if (cur_addr !== 3'd5) begin miscompares++; $display("FAIL abort_cur_addr got %0d want 5", cur_addr); end
        vectors++; if (last_sample !== 12'h001) begin miscompares++; $display("FAIL abort_last_sample got %h want 001", last_sample); end
    endtask

    task automatic test_ch_change;
        logic [95:0] nv;
        logic [15:0] rx;
        nv = ch_data;
        nv[60 +: 12] = 12'h555;
        run_frame(3'd5, 6, nv, 0, rx);
        vectors++; if (rx !== 16'h0ABC) begin miscompares++; $display("FAIL chg_in_frame got %h want 0ABC", rx); end
        run_frame(3'd3, 0, ch_data, 0, rx);
        vectors++; if (rx !== 16'h0555) begin miscompares++; $display("FAIL chg_next_frame got %h want 0555", rx); end
        vectors++; if (cur_addr !== 3'd3) begin miscompares++; $display("FAIL chg_cur_addr got %0d want 3", cur_addr); end
    endtask

    // Reset mid-frame with cs_n held low: frame is abandoned, address returns to INIT_ADDR.
    task automatic test_reset_mid_frame;
        logic [15:0] rx;
        int d0;
        d0 = done_cnt;
        run_frame(3'd6, 0, ch_data, 7, rx);
        vectors++; if (rx !== 16'h0000) begin miscompares++; $display("FAIL rstmid_data got %h want 0000", rx); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL rstmid_done got %0d want 0", done_cnt - d0); end
        vectors++; if (cur_addr !== 3'd0) begin miscompares++; $display("FAIL rstmid_cur_addr got %0d want 0", cur_addr); end
        vectors++; if (last_sample !== 12'h000) begin miscompares++; $display("FAIL rstmid_last_sample got %h want 000", last_sample); end
        d0 = done_cnt;
        run_frame(3'd0, 0, ch_data, 0, rx);
        vectors++; if (rx !== 16'h0123) begin miscompares++; $display("FAIL rstmid_next_data got %h want 0123", rx); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rstmid_next_done got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        ch_data = '0;
        ch_data[0  +: 12] = 12'h123;
        ch_data[36 +: 12] = 12'h3C3;
        ch_data[60 +: 12] = 12'hABC;
        ch_data[72 +: 12] = 12'h7FF;
        ch_data[84 +: 12] = 12'h001;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_ch_change();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
